// File: rtl/seg_scan_decoder.sv
// Scan-bus loopback decoder: rebuilds the 6-digit hex frame from the muxed seven-segment bus.
// Optional invalid-select/glitch counter on err_count is built only when SEGDEC_ERRCNT_EN is defined.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  digit,
    input  logic [5:0]  select,
    output logic [23:0] value,
    output logic [5:0]  dp,
    output logic [5:0]  blank,
    output logic [5:0]  bad,
    output logic        frame_valid,
    output logic        stale,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t      state;
    logic [7:0]  dig_m, dig_s, ref_dig;
    logic [5:0]  sel_m, sel_s, ref_sel;
    logic [7:0]  cnt;
    logic [19:0] tcnt;
    logic [23:0] sh_val;
    logic [5:0]  sh_dp, sh_blank, sh_bad, seen, cap_oh;
    logic [5:0]  dec;
    logic        frame_done, sel_1h;

    // {bad, blank, nibble} from active-high g..a
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = 6'h00;
            7'h06: decode = 6'h01;
            7'h5B: decode = 6'h02;
            7'h4F: decode = 6'h03;
            7'h66: decode = 6'h04;
            7'h6D: decode = 6'h05;
            7'h7D: decode = 6'h06;
            7'h07: decode = 6'h07;
            7'h7F: decode = 6'h08;
            7'h6F: decode = 6'h09;
            7'h77: decode = 6'h0A;
            7'h7C: decode = 6'h0B;
            7'h39: decode = 6'h0C;
            7'h5E: decode = 6'h0D;
            7'h79: decode = 6'h0E;
            7'h71: decode = 6'h0F;
            7'h00: decode = 6'b010000;
            default: decode = 6'b100000;
        endcase
    endfunction

    assign sel_1h = ($countones(~sel_s) == 1);
    assign cap_oh = ~ref_sel;
    assign dec    = decode(~ref_dig[6:0]);

    // Bus idles high, so the synchronizer resets to the blanking pattern
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_m <= '1;
            dig_s <= '1;
            sel_m <= '1;
            sel_s <= '1;
        end else begin
            dig_m <= digit;
            dig_s <= dig_m;
            sel_m <= select;
            sel_s <= sel_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ref_sel <= '1;
            ref_dig <= '1;
        end else begin
            case (state)
                IDLE: if (sel_1h) begin
                    state   <= SETTLE;
                    cnt     <= 8'd1;
                    ref_sel <= sel_s;
                    ref_dig <= dig_s;
                end
                SETTLE: begin
                    if (sel_s != ref_sel) begin
                        if (sel_1h) begin
                            cnt     <= 8'd1;
                            ref_sel <= sel_s;
                            ref_dig <= dig_s;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (dig_s != ref_dig) begin
                        cnt     <= 8'd1;
                        ref_dig <= dig_s;
                    end else if (cnt >= 8'(SETTLE_CYCLES)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CAPTURE: state <= DONE;
                DONE: if (sel_s != ref_sel) begin
                    if (sel_1h) begin
                        state   <= SETTLE;
                        cnt     <= 8'd1;
                        ref_sel <= sel_s;
                        ref_dig <= dig_s;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow frame fills slot by slot; outputs copy it the cycle after the last slot lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_val      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_bad      <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            value       <= '0;
            dp          <= '0;
            blank       <= '0;
            bad         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_done  <= (state == CAPTURE) && ((seen | cap_oh) == 6'h3F);
            if (frame_done) begin
                value       <= sh_val;
                dp          <= sh_dp;
                blank       <= sh_blank;
                bad         <= sh_bad;
                seen        <= '0;
                frame_valid <= 1'b1;
            end
            if (state == CAPTURE) begin
                seen <= seen | cap_oh;
                for (int i = 0; i < 6; i++) begin
                    if (cap_oh[i]) begin
                        sh_val[4*i +: 4] <= dec[3:0];
                        sh_blank[i]      <= dec[4];
                        sh_bad[i]        <= dec[5];
                        sh_dp[i]         <= ~ref_dig[7];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (state == CAPTURE) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else begin
            if (tcnt < 20'(TIMEOUT_CYCLES)) tcnt <= tcnt + 20'd1;
            if (tcnt >= 20'(TIMEOUT_CYCLES - 1)) stale <= 1'b1;
        end
    end

`ifdef SEGDEC_ERRCNT_EN
    logic sel_ill, ill_q, glitch;
    assign sel_ill = !sel_1h && (sel_s != 6'h3F);
    assign glitch  = (state == SETTLE) && (sel_s == ref_sel) && (dig_s != ref_dig);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ill_q     <= 1'b0;
            err_count <= '0;
        end else begin
            ill_q <= sel_ill;
            if (((sel_ill && !ill_q) || glitch) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: run-length reference model of the scan bus, directed scans plus random scans.
module tb_seg_scan_decoder;
    localparam int S    = 8;
    localparam int T    = 1000;
    localparam int MAXN = 4096;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  digit = 8'hFF;
    logic [5:0]  select = 6'h3F;
    logic [23:0] value;
    logic [5:0]  dp, blank, bad;
    logic        frame_valid, stale;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .digit(digit), .select(select), .value(value), .dp(dp),
        .blank(blank), .bad(bad), .frame_valid(frame_valid), .stale(stale), .err_count(err_count)
    );

    int          tests = 0;
    int          fails = 0;
    logic [5:0]  s_arr [MAXN];
    logic [7:0]  d_arr [MAXN];
    logic [51:0] exp_arr [MAXN];
    int          n;
    int          fv_cnt;
    int          mark;
    logic        mark_stale;
    logic [23:0] fr_val;
    logic [5:0]  fr_dp, fr_bl, fr_bad;

    task automatic check(input string name, input logic [51:0] got, input logic [51:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [5:0] sel_of(input int i);
        logic [5:0] b;
        b = 6'(1 << i);
        return ~b;
    endfunction

    function automatic logic [7:0] pat(input int v, input bit dpon);
        return ~{dpon, GLYPH[v]};
    endfunction

    function automatic bit onehot(input logic [5:0] s);
        return $countones(~s) == 1;
    endfunction

    function automatic bit illegal(input logic [5:0] s);
        return !onehot(s) && s != 6'h3F;
    endfunction

    task automatic mdec(input logic [7:0] d, output logic [3:0] nib, output logic xdp,
                        output logic xbl, output logic xbad);
        logic [6:0] seg;
        seg  = ~d[6:0];
        nib  = 4'h0;
        xdp  = ~d[7];
        xbl  = (seg == 7'h00);
        xbad = (seg != 7'h00);
        for (int v = 0; v < 16; v++)
            if (GLYPH[v] == seg) begin
                nib  = 4'(v);
                xbad = 1'b0;
            end
    endtask

    // Identical back-to-back runs would merge; split them with one blanking cycle
    task automatic push(input logic [5:0] s, input logic [7:0] d, input int len);
        if (n > 0 && n < MAXN && onehot(s) && s == s_arr[n-1] && d == d_arr[n-1]) begin
            s_arr[n] = 6'h3F;
            d_arr[n] = 8'hFF;
            n++;
        end
        for (int i = 0; i < len; i++)
            if (n < MAXN) begin
                s_arr[n] = s;
                d_arr[n] = d;
                n++;
            end
    endtask

    // Reference: a stable (select,digit) run of length >= S+1 is captured once per select
    // assertion, landing in the shadow S+3 edges after its first sample; frame shows one edge later.
    task automatic build_model();
        int          cq[$], cslot[$], eq[$];
        logic [7:0]  cpat[$];
        logic [5:0]  ps, sdp, sbl, sbad, seen, odp, obl, obad;
        logic [7:0]  pd, errv;
        logic [23:0] sv, ov;
        logic [3:0]  nb;
        logic        xd, xb, xbad;
        bit          got, pend, fv, st;
        int          L, slot, last, err, qi, ei;
        got = 0;
        for (int c = 0; c < n; c++) begin
            ps = (c == 0) ? 6'h3F : s_arr[c-1];
            pd = (c == 0) ? 8'hFF : d_arr[c-1];
            if (s_arr[c] != ps) got = 0;
            if (illegal(s_arr[c]) && !illegal(ps)) eq.push_back(c + 2);
            if (onehot(s_arr[c]) && (s_arr[c] != ps || d_arr[c] != pd) && !got) begin
                if (s_arr[c] == ps) eq.push_back(c + 2);
                L = 0;
                while (c + L < n && s_arr[c+L] == s_arr[c] && d_arr[c+L] == d_arr[c]) L++;
                if (L >= S + 1) begin
                    slot = 0;
                    for (int i = 0; i < 6; i++) if (!s_arr[c][i]) slot = i;
                    got = 1;
                    cq.push_back(c + S + 3);
                    cslot.push_back(slot);
                    cpat.push_back(d_arr[c]);
                end
            end
        end
        sv = '0; sdp = '0; sbl = '0; sbad = '0; seen = '0;
        ov = '0; odp = '0; obl = '0; obad = '0;
        pend = 0; last = -1; err = 0; qi = 0; ei = 0;
        for (int e = 0; e < n; e++) begin
            fv = 0;
            if (pend) begin
                ov = sv; odp = sdp; obl = sbl; obad = sbad;
                seen = '0; fv = 1; pend = 0;
            end
            while (ei < eq.size() && eq[ei] == e) begin
                if (err < 255) err++;
                ei++;
            end
            if (qi < cq.size() && cq[qi] == e) begin
                mdec(cpat[qi], nb, xd, xb, xbad);
                sv[4*cslot[qi] +: 4] = nb;
                sdp[cslot[qi]]  = xd;
                sbl[cslot[qi]]  = xb;
                sbad[cslot[qi]] = xbad;
                seen[cslot[qi]] = 1'b1;
                last = e;
                if (seen == 6'h3F) pend = 1;
                qi++;
            end
            st = (e - last >= T);
`ifdef SEGDEC_ERRCNT_EN
            errv = 8'(err);
`else
            errv = 8'h00;
`endif
            exp_arr[e] = {ov, odp, obl, obad, fv, st, errv};
        end
    endtask

    task automatic run_phase(input int rst_cycles);
        build_model();
        @(posedge clk); #1;
        rst = 1'b0; select = 6'h3F; digit = 8'hFF;
        for (int i = 0; i < rst_cycles; i++) begin
            @(posedge clk); #1;
            check("reset", {value, dp, blank, bad, frame_valid, stale, err_count}, 52'd0);
        end
        rst = 1'b1; select = s_arr[0]; digit = d_arr[0]; fv_cnt = 0; mark_stale = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check($sformatf("cycle%0d", k), {value, dp, blank, bad, frame_valid, stale, err_count}, exp_arr[k]);
            if (frame_valid) begin
                fv_cnt++;
                fr_val = value; fr_dp = dp; fr_bl = blank; fr_bad = bad;
            end
            if (k == mark) mark_stale = stale;
            if (k + 1 < n) begin
                select = s_arr[k+1];
                digit  = d_arr[k+1];
            end
        end
    endtask

    task automatic scan(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5, input int cnt);
        logic [7:0] ds [6];
        ds = '{d0, d1, d2, d3, d4, d5};
        for (int i = 0; i < cnt; i++) begin
            push(sel_of(i), ds[i], 20);
            push(6'h3F, 8'hFF, 4);
        end
    endtask

    function automatic logic [7:0] rand_pat();
        int         r;
        logic [6:0] seg;
        r = $urandom_range(0, 9);
        if (r == 0) seg = 7'h00;
        else if (r == 1) seg = 7'($urandom);
        else seg = GLYPH[$urandom_range(0, 15)];
        return ~{1'($urandom), seg};
    endfunction

    task automatic gen_random();
        logic [5:0] s;
        logic [7:0] d, pdg;
        int         a, b, subs;
        n = 0;
        while (n < 2600) begin
            if ($urandom_range(0, 19) == 0) begin
                a = $urandom_range(0, 5);
                b = (a + $urandom_range(1, 5)) % 6;
                s = sel_of(a) & sel_of(b) & 6'($urandom | $urandom);
                push(s, 8'($urandom), $urandom_range(1, 6));
            end else begin
                s = sel_of($urandom_range(0, 5));
                subs = $urandom_range(1, 3);
                pdg = 8'h00;
                for (int j = 0; j < subs; j++) begin
                    d = rand_pat();
                    if (j > 0 && d == pdg) d = d ^ 8'h01;
                    pdg = d;
                    push(s, d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1)
                                                            : $urandom_range(S + 3, S + 16));
                end
            end
            push(6'h3F, 8'hFF, $urandom_range(0, 4));
        end
    endtask

    initial begin
        mark = -1;

        // 123456 plain scan
        n = 0;
        scan(pat(1,0), pat(2,0), pat(3,0), pat(4,0), pat(5,0), pat(6,0), 6);
        push(6'h3F, 8'hFF, 10);
        run_phase(3);
        check("p1_frames", 52'(fv_cnt), 52'd1);
        check("p1_value", 52'(fr_val), 52'h654321);
        check("p1_blank_bad", 52'({fr_bl, fr_bad}), 52'd0);

        // dp on digit 2, digit 4 dark
        n = 0;
        scan(pat(1,0), pat(2,0), pat(3,1), pat(4,0), 8'hFF, pat(6,0), 6);
        push(6'h3F, 8'hFF, 10);
        run_phase(2);
        check("p2_dp", 52'(fr_dp), 52'b000100);
        check("p2_blank", 52'(fr_bl), 52'b010000);
        check("p2_value", 52'(fr_val), 52'h604321);

        // illegal glyph on digit 1
        n = 0;
        scan(pat(1,0), 8'hAA, pat(3,0), pat(4,0), pat(5,0), pat(6,0), 6);
        push(6'h3F, 8'hFF, 10);
        run_phase(2);
        check("p3_bad", 52'(fr_bad), 52'b000010);
        check("p3_value", 52'(fr_val), 52'h654301);

        // digit 0 too short to settle -> stale, then one good scan
        n = 0;
        for (int i = 0; i < 100; i++) begin
            push(sel_of(0), pat(1,0), S - 1);
            push(6'h3F, 8'hFF, 4);
        end
        mark = n - 1;
        scan(pat(1,0), pat(2,0), pat(3,0), pat(4,0), pat(5,0), pat(6,0), 6);
        push(6'h3F, 8'hFF, 10);
        run_phase(2);
        mark = -1;
        check("p4_stale_set", 52'(mark_stale), 52'd1);
        check("p4_stale_clr", 52'(stale), 52'd0);
        check("p4_frames", 52'(fv_cnt), 52'd1);

        // illegal select window then a one-cycle digit toggle mid-settle
        n = 0;
        push(6'b111100, pat(2,0), 10);
        push(sel_of(0), pat(1,0), 4);
        push(sel_of(0), pat(7,0), 1);
        push(sel_of(0), pat(1,0), 20);
        push(6'h3F, 8'hFF, 6);
        run_phase(2);
        check("p5_frames", 52'(fv_cnt), 52'd0);
`ifdef SEGDEC_ERRCNT_EN
        check("p5_err", 52'(err_count), 52'd3);
`else
        check("p5_err", 52'(err_count), 52'd0);
`endif

        // reset after four captures, then a full scan
        n = 0;
        scan(pat(10,0), pat(11,0), pat(12,0), pat(13,0), 8'hFF, 8'hFF, 4);
        run_phase(2);
        check("p6a_frames", 52'(fv_cnt), 52'd0);
        n = 0;
        scan(pat(9,0), pat(8,0), pat(7,0), pat(6,0), pat(5,0), pat(4,0), 6);
        push(6'h3F, 8'hFF, 10);
        run_phase(3);
        check("p6_frames", 52'(fv_cnt), 52'd1);
        check("p6_value", 52'(fr_val), 52'h456789);

        for (int r = 0; r < 6; r++) begin
            gen_random();
            run_phase(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
